// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential word fetches, buffers in-order
// responses in a credit-limited FIFO and flushes everything on a redirect.
module fetch_unit #(
    parameter int unsigned                PC_WIDTH_LENGTH = 32,
    parameter int unsigned                INST_WIDTH      = 32,
    parameter int unsigned                DEPTH           = 4,
    parameter logic [PC_WIDTH_LENGTH-1:0] RESET_PC        = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_valid,
    input  logic [PC_WIDTH_LENGTH-1:0] redirect_pc,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [PC_WIDTH_LENGTH-1:0] imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [INST_WIDTH-1:0]      imem_rsp_data,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [INST_WIDTH-1:0]      inst_out,
    output logic [PC_WIDTH_LENGTH-1:0] inst_pc
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] L_DEPTH = (CW + 1)'(DEPTH);
    localparam logic [PC_WIDTH_LENGTH-1:0] L_PC_STEP = PC_WIDTH_LENGTH'(4);

    logic [PC_WIDTH_LENGTH-1:0] r_fetch_pc;
    logic [PC_WIDTH_LENGTH-1:0] r_rsp_pc;
    logic [INST_WIDTH-1:0]      r_fifo_inst [DEPTH];
    logic [PC_WIDTH_LENGTH-1:0] r_fifo_pc   [DEPTH];
    logic [PW-1:0]              r_rd_ptr;
    logic [PW-1:0]              r_wr_ptr;
    logic [CW-1:0]              r_count;
    logic [CW-1:0]              r_outstanding;
    logic [CW-1:0]              r_drop;

    logic [CW:0]                w_credit_used;
    logic                       w_req_valid;
    logic                       w_req_fire;
    logic                       w_rsp_counted;
    logic                       w_rsp_keep;
    logic                       w_inst_valid;
    logic                       w_pop;
    logic [PC_WIDTH_LENGTH-1:0] w_redirect_target;
    logic [CW-1:0]              w_outstanding_after_rsp;
    logic [CW-1:0]              w_outstanding_next;
    logic [CW-1:0]              w_count_next;
    logic                       w_unused_low_bits;

    // Credits cover both in-flight requests and buffered entries, so the FIFO cannot overflow.
    assign w_credit_used     = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_req_valid       = !rst && !redirect_valid && (w_credit_used < L_DEPTH);
    assign w_req_fire        = w_req_valid && imem_req_ready;
    assign w_rsp_counted     = imem_rsp_valid && (r_outstanding != CW'(0));
    assign w_rsp_keep        = !rst && !redirect_valid && w_rsp_counted && (r_drop == CW'(0));
    assign w_inst_valid      = !rst && !redirect_valid && (r_count != CW'(0));
    assign w_pop             = w_inst_valid && inst_ready;
    assign w_redirect_target = {redirect_pc[PC_WIDTH_LENGTH-1:2], 2'b00};
    assign w_unused_low_bits = ^redirect_pc[1:0];

    assign w_outstanding_after_rsp = r_outstanding - CW'(w_rsp_counted);
    assign w_outstanding_next      = w_outstanding_after_rsp + CW'(w_req_fire);
    assign w_count_next            = r_count + CW'(w_rsp_keep) - CW'(w_pop);

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign inst_valid     = w_inst_valid;
    assign inst_out       = r_fifo_inst[r_rd_ptr];
    assign inst_pc        = r_fifo_pc[r_rd_ptr];

    // Control state: PCs, FIFO pointers, credit and drop counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_rd_ptr      <= PW'(0);
            r_wr_ptr      <= PW'(0);
            r_count       <= CW'(0);
            r_outstanding <= CW'(0);
            r_drop        <= CW'(0);
        end else if (redirect_valid) begin
            // Everything still in flight belongs to the squashed path.
            r_fetch_pc    <= w_redirect_target;
            r_rsp_pc      <= w_redirect_target;
            r_rd_ptr      <= PW'(0);
            r_wr_ptr      <= PW'(0);
            r_count       <= CW'(0);
            r_outstanding <= w_outstanding_after_rsp;
            r_drop        <= w_outstanding_after_rsp;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + L_PC_STEP;
            end
            if (w_rsp_counted && (r_drop != CW'(0))) begin
                r_drop <= r_drop - CW'(1);
            end
            if (w_rsp_keep) begin
                r_rsp_pc <= r_rsp_pc + L_PC_STEP;
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_outstanding <= w_outstanding_next;
            r_count       <= w_count_next;
        end
    end

    // FIFO payload storage; validity is tracked by r_count so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_rsp_keep) begin
            r_fifo_inst[r_wr_ptr] <= imem_rsp_data;
            r_fifo_pc[r_wr_ptr]   <= r_rsp_pc;
        end
    end

endmodule
